// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bus controller between the CPU memory port and a word RAM
// with synchronous write and combinational read. It accepts one request at a
// time, inserts WAIT_STATES idle cycles, drives the RAM for one access cycle
// and returns a one-cycle cpu_ack pulse along with the read data.
//
// Optional feature (macro SIM_CTRL_EN): a simulation-control word at
// SIM_CTRL_ADDR. Writes there are consumed by the controller, and writing
// SIM_STOP_WORD sets the sticky sim_end flag. Reads there return
// {31'b0, sim_end}. Without the macro, sim_end is tied low and SIM_CTRL_ADDR
// is ordinary RAM.
//
// Ports:
//   clock        system clock, all state on posedge
//   reset        synchronous, active-high
//   cpu_req      request, held with all cpu_* inputs until cpu_ack
//   cpu_write    1 = write, 0 = read
//   cpu_address  word address
//   cpu_wdata    write data (bit 0 = MSB)
//   cpu_ack      one-cycle completion pulse
//   cpu_rdata    read data, valid while cpu_ack = 1
//   mem_address  RAM word address (held outside the access cycle)
//   mem_write_en RAM write strobe
//   mem_wdata    RAM write data (held outside the access cycle)
//   mem_rdata    RAM combinational read data
//   sim_end      sticky stop flag
module mem_bus_ctrl #(
  parameter int unsigned  WAIT_STATES   = 2,
  parameter logic [15:31] SIM_CTRL_ADDR = 17'h00100,
  parameter logic [0:31]  SIM_STOP_WORD = 32'h00010001
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_write,
  input  logic [15:31] cpu_address,
  input  logic [0:31]  cpu_wdata,
  output logic         cpu_ack,
  output logic [0:31]  cpu_rdata,
  output logic [15:31] mem_address,
  output logic         mem_write_en,
  output logic [0:31]  mem_wdata,
  input  logic [0:31]  mem_rdata,
  output logic         sim_end
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_ACK} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t        state;
  state_t        state_next;
  logic [3:0]    cnt;
  logic [15:31]  addr_q;
  logic [0:31]   wdata_q;
  logic          write_q;
  logic [15:31]  addr_hold;
  logic [0:31]   wdata_hold;
  logic          in_access;
  logic          ctrl_hit;
  logic [0:31]   read_word;

`ifdef SIM_CTRL_EN
  logic sim_end_q;
  assign ctrl_hit  = (addr_q == SIM_CTRL_ADDR);
  assign read_word = ctrl_hit ? {31'b0, sim_end_q} : mem_rdata;
  assign sim_end   = sim_end_q;
`else
  assign ctrl_hit  = 1'b0;
  assign read_word = mem_rdata;
  assign sim_end   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cpu_ack    = 1'b0;
    in_access  = 1'b0;
    unique case (state)
      S_IDLE:   if (cpu_req) state_next = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt == 4'd1) state_next = S_ACCESS;
      S_ACCESS: begin
        in_access  = 1'b1;
        state_next = S_ACK;
      end
      S_ACK: begin
        cpu_ack    = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // The strobe looks at reset directly so a reset landing in the access
  // cycle blocks the RAM write at that same edge.
  assign mem_write_en = in_access && write_q && !reset && !ctrl_hit;

  // Address/data show the latched request only during the access cycle and
  // otherwise keep whatever was last presented to the RAM.
  assign mem_address = in_access ? addr_q  : addr_hold;
  assign mem_wdata   = in_access ? wdata_q : wdata_hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      cpu_rdata  <= '0;
`ifdef SIM_CTRL_EN
      sim_end_q  <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && cpu_req) begin
        addr_q  <= cpu_address;
        wdata_q <= cpu_wdata;
        write_q <= cpu_write;
        cnt     <= WAIT_INIT;
      end
      if (state == S_WAIT) cnt <= cnt - 4'd1;
      if (in_access) begin
        addr_hold  <= addr_q;
        wdata_hold <= wdata_q;
        if (!write_q) cpu_rdata <= read_word;
`ifdef SIM_CTRL_EN
        if (write_q && ctrl_hit && wdata_q == SIM_STOP_WORD) sim_end_q <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Bus controller between the CPU's memory port and the synchronous-write, combinational-read word RAM.
- Accepts one request at a time over a req/ack handshake.
- Inserts a programmable number of wait states, then drives the RAM for exactly one access cycle.
- Returns read data with a one-cycle ack pulse.
- Optionally decodes a simulation-control word. Writing the stop pattern there raises a sticky sim_end flag that the bench watches.

Parameters:
WAIT_STATES, 2, idle cycles between request acceptance and RAM access (0..15)
SIM_CTRL_ADDR, 17'h00100, word address of the simulation-control register (used only with SIM_CTRL_EN)
SIM_STOP_WORD, 32'h00010001, data pattern that sets sim_end

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high
cpu_req  input  1  request; CPU holds it and all cpu_* inputs stable until cpu_ack
cpu_write  input  1  1 = write, 0 = read
cpu_address  input  [15:31]  word address
cpu_wdata  input  [0:31]  write data, bit 0 = MSB
cpu_ack  output  1  one-cycle completion pulse
cpu_rdata  output  [0:31]  read data, valid while cpu_ack = 1
mem_address  output  [15:31]  RAM word address
mem_write_en  output  1  RAM write strobe
mem_wdata  output  [0:31]  RAM write data
mem_rdata  input  [0:31]  RAM combinational read data
sim_end  output  1  sticky stop flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state = IDLE, cpu_ack = 0, cpu_rdata = 0, mem_write_en = 0, mem_address = 0, mem_wdata = 0, sim_end = 0, wait counter = 0.
- States: IDLE, WAIT, ACCESS, ACK.
- IDLE: when cpu_req = 1 at the edge:
  - latch address, wdata and write into internal registers;
  - load counter = WAIT_STATES;
  - go to WAIT if WAIT_STATES > 0, else go to ACCESS.
- WAIT: counter decrements each cycle; go to ACCESS on the edge where counter == 1.
- ACCESS (exactly one cycle):
  - mem_address and mem_wdata = latched values; these outputs hold their last values in all other states.
  - mem_write_en = latched write AND NOT reset. It is combinational from state, so asserting reset during ACCESS suppresses the write.
  - For a read, mem_rdata is captured into cpu_rdata at the end of the cycle.
  - Then go to ACK.
- ACK: cpu_ack = 1 for one cycle; cpu_rdata holds the captured value (for a write it holds its previous value); go to IDLE.
- Latency: request sampled in cycle 0 → cpu_ack high in cycle WAIT_STATES+2.
  - Back-to-back requests: next cpu_req is sampled in the cycle after ACK.
  - Period = WAIT_STATES+3.
- cpu_req deasserted before ack is a protocol violation; the latched request still completes normally.
- A request present in the ACK cycle is not accepted until IDLE.
- Reset at any state aborts the transaction: no ack, no write, and the latched request is discarded.
- Address is passed through unmasked; the RAM applies its own mask.

Optional Feature:
SIM_CTRL_EN
- Defined:
  - A write to SIM_CTRL_ADDR is consumed by the controller: mem_write_en stays 0 in ACCESS, ack is normal.
  - If the data equals SIM_STOP_WORD, sim_end is set in the ACCESS cycle and stays 1 until reset. Any other data leaves sim_end unchanged.
  - A read of SIM_CTRL_ADDR returns {31'b0, sim_end} and ignores mem_rdata.
- Undefined: sim_end is tied 0, and SIM_CTRL_ADDR is ordinary RAM.

Test Plan:
1. Reset, then read addr 17'h00004 with RAM[4] = 32'hDEADBEEF, WAIT_STATES = 2 → ack in cycle 4 after req sampled, cpu_rdata = 32'hDEADBEEF, mem_write_en never high.
2. Write 32'h12345678 to 17'h00010, then read back → mem_write_en high for exactly one cycle (cycle 3); readback = 32'h12345678; second req accepted in cycle 5 (period 5).
3. WAIT_STATES = 0 → ack two cycles after req sampled; four back-to-back reads complete in 12 cycles.
4. Assert reset during the ACCESS cycle of a write to 17'h00020 → RAM[0x20] unchanged, no ack, state IDLE next cycle, all outputs at reset values.
5. SIM_CTRL_EN defined:
   - write 32'h00010000 to 17'h00100 → sim_end stays 0;
   - then write 32'h00010001 → sim_end = 1 at the following edge, RAM[0x100] unchanged;
   - read 17'h00100 → 32'h00000001.
6. SIM_CTRL_EN undefined, same writes → sim_end stays 0 and RAM[0x100] = 32'h00010001.
